pic_sync_controller: RTL and testbench
======================================

# pic_sync_controller

Parametrised, fully synchronous successor to the 8259A-style interrupt controller. It has NUM_IRQ request channels with per-channel edge/level trigger and a flat register bus in place of the 8080 bus. It supports fully-nested priority with optional automatic rotation, specific and non-specific EOI, and automatic EOI. It delivers the vector through a clocked INTA request/vector handshake. It sits between the peripheral IR lines and the CPU interrupt interface, in the same position as the existing PIC.

## Interface
- NUM_IRQ, 8, number of request channels, 2..32
- ID_W, $clog2(NUM_IRQ), width of a channel index (derived, not overridable)
- CLK  in  1  clock; all logic on rising edge
- RST  in  1  synchronous, active-high reset
- IR  in  NUM_IRQ  request lines, already synchronous to CLK
- CS  in  1  register access select
- WR  in  1  write strobe, one cycle, qualified by CS
- RD  in  1  read strobe, one cycle, qualified by CS
- ADDR  in  3  register index
- WDATA  in  32  write data
- RDATA  out  32  read data, registered
- INTA  in  1  acknowledge pulse from CPU, one cycle
- INT  out  1  interrupt request to CPU, registered
- VEC_VALID  out  1  one-cycle strobe, VECTOR valid
- VECTOR  out  8  interrupt vector
- SPURIOUS  out  1  qualifies VEC_VALID: no eligible request at resolve

## Operation
- Registers, bits above NUM_IRQ read 0 and ignore writes:
  - 0 CTRL: bit0 ROT (auto-rotate on EOI), bit1 AEOI.
  - 1 IMR: 1 = masked.
  - 2 TRIG: 1 = level, 0 = edge.
  - 3 VBASE[7:0].
  - 4 EOI, write-only: WDATA[8]=1 selects specific EOI of level WDATA[4:0]; otherwise non-specific. Reads 0.
  - 5 IRR, read-only.
  - 6 ISR, read-only.
  - 7 LOWPRI, read-only, rotation pointer.
- Edge channel: IRR bit sets on IR 0→1, using a registered IR copy (reset 0). It clears when the channel is acknowledged. It holds otherwise.
- Level channel: IRR bit = IR, registered each cycle. The acknowledge clear is not applied.
- Priority order: channel (LOWPRI+1) mod NUM_IRQ is highest, descending cyclically to LOWPRI.
- A request is eligible when its IRR bit is 1, its IMR bit is 0, and it is strictly higher priority than the highest set ISR bit (or ISR is 0).
- INT = registered OR of eligible requests.
- FSM states IDLE, RESOLVE, VECTOR:
  - IDLE: INTA=1 → RESOLVE. INTA in any other state is ignored.
  - RESOLVE: select the highest eligible channel k, using register state of this cycle. Set ISR[k]. Clear IRR[k] if edge. Next state VECTOR. If none is eligible, set no bit and go to VECTOR with SPURIOUS.
  - VECTOR: VEC_VALID=1, VECTOR=VBASE+k (8-bit wrap), SPURIOUS=0. Spurious case: VECTOR=VBASE+NUM_IRQ-1, SPURIOUS=1. If AEOI, clear ISR[k] this cycle and apply ROT rule. Next state IDLE.
- Non-specific EOI clears the highest-priority set ISR bit; no-op if ISR=0. Specific EOI clears ISR[level]; no-op if level ≥ NUM_IRQ or bit already 0.
- ROT=1: any EOI that clears bit j, including AEOI, sets LOWPRI ← j.

## Timing
- Reset values: CTRL 0, IMR all 1, TRIG 0, VBASE 0, IRR 0, ISR 0, LOWPRI NUM_IRQ-1, IR copy 0, state IDLE. Outputs RDATA 0, INT 0, VEC_VALID 0, VECTOR 0, SPURIOUS 0.
- RST mid-handshake returns to IDLE next cycle; no VEC_VALID is emitted.
- Register writes take effect the cycle after WR.
- RDATA is valid the cycle after RD and holds until the next RD.
- Edge on IR at cycle n: IRR set at n+1, INT at n+2 (if eligible).
- INTA at cycle n: RESOLVE at n+1, VEC_VALID at n+2, back to IDLE at n+3. Earliest next accepted INTA is n+3.
- INT recomputes every cycle, including after the ISR update, so it drops by n+2 if nothing else is eligible.
- Simultaneous events:
  - A new rising edge in the same cycle RESOLVE clears that IRR bit leaves it set.
  - EOI write in the same cycle as an ISR set of the same bit: the set wins.
  - IMR/TRIG write in the same cycle as RESOLVE: RESOLVE uses the old value.
  - Level request deasserted before RESOLVE: the acknowledge is spurious.

## Test plan
- Reset: after RST, IMR=0xFF, RDATA 0, INT 0, VEC_VALID 0; pulse IR[3] → INT stays 0 (masked).
- Basic: IMR=0, VBASE=0x40, pulse IR[3] → INT at +2; INTA → VEC_VALID 2 cycles later with VECTOR=0x43, ISR=0x08, IRR=0; EOI 0x000 → ISR=0.
- Nesting: IR[5] acknowledged (ISR=0x20); raise IR[6] → INT stays 0; raise IR[2] → INT=1; ack → VECTOR=VBASE+2, ISR=0x24; non-specific EOI clears bit 2 first.
- Rotation+AEOI: CTRL=3, IR[0] and IR[1] pending → first ack vector +0, LOWPRI=0; second ack vector +1; ISR remains 0 throughout.
- Spurious/level: TRIG[4]=1, IR[4] high then dropped before RESOLVE → VECTOR=VBASE+NUM_IRQ-1, SPURIOUS=1, ISR unchanged.
- NUM_IRQ=32 with VBASE=0xF0: ack of IR[20] → VECTOR=0x04 (wrap); RST during RESOLVE → no VEC_VALID, ISR=0.

Source files
------------

// File: rtl/pic_sync_controller.sv
// rtl/pic_sync_controller.sv - parametrised synchronous 8259A-style interrupt controller
module pic_sync_controller #(
    parameter int NUM_IRQ = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [NUM_IRQ-1:0] ir_i,
    input  logic               cs_i,
    input  logic               wr_i,
    input  logic               rd_i,
    input  logic [2:0]         addr_i,
    input  logic [31:0]        wdata_i,
    output logic [31:0]        rdata_o,
    input  logic               inta_i,
    output logic               int_o,
    output logic               vec_valid_o,
    output logic [7:0]         vector_o,
    output logic               spurious_o
);
    localparam int ID_W = $clog2(NUM_IRQ);

    typedef enum logic [1:0] {S_IDLE, S_RESOLVE, S_VECTOR} state_t;

    state_t             state_q;
    logic [1:0]         ctrl_q;
    logic [NUM_IRQ-1:0] imr_q, trig_q, irr_q, isr_q, ir_q;
    logic [7:0]         vbase_q, vector_q;
    logic [ID_W-1:0]    lowpri_q, sel_q;
    logic [31:0]        rdata_q;
    logic               int_q, vec_valid_q, spurious_q;

    logic [NUM_IRQ-1:0] elig_now, set_mask, ack_clr, eoi_clr, rise, irr_d, isr_d;
    logic [ID_W-1:0]    lowpri_d, sel_idx;
    logic [31:0]        rd_mux;
    logic               found, int_d;
    int                 sel_ch, svc_ch, lvl;
    logic               unused_wdata;

    // Rank 0 is the channel just after LOWPRI; LOWPRI itself ranks last.
    function automatic int prio_rank(input int ch, input logic [ID_W-1:0] low);
        return (ch + 2 * NUM_IRQ - int'(low) - 1) % NUM_IRQ;
    endfunction

    function automatic int top_of(input logic [NUM_IRQ-1:0] mask, input logic [ID_W-1:0] low);
        int best;
        int best_rank;
        best      = -1;
        best_rank = NUM_IRQ;
        for (int ch = 0; ch < NUM_IRQ; ch++) begin
            if (mask[ch] && prio_rank(ch, low) < best_rank) begin
                best      = ch;
                best_rank = prio_rank(ch, low);
            end
        end
        return best;
    endfunction

    function automatic logic [NUM_IRQ-1:0] eligible(input logic [NUM_IRQ-1:0] irr,
                                                    input logic [NUM_IRQ-1:0] imr,
                                                    input logic [NUM_IRQ-1:0] isr,
                                                    input logic [ID_W-1:0]    low);
        int                 in_svc;
        int                 lim;
        logic [NUM_IRQ-1:0] m;
        in_svc = top_of(isr, low);
        lim    = (in_svc < 0) ? NUM_IRQ : prio_rank(in_svc, low);
        for (int ch = 0; ch < NUM_IRQ; ch++) begin
            m[ch] = irr[ch] & ~imr[ch] & (prio_rank(ch, low) < lim);
        end
        return m;
    endfunction

    assign unused_wdata = ^wdata_i;

    always_comb begin
        elig_now = eligible(irr_q, imr_q, isr_q, lowpri_q);
        sel_ch   = top_of(elig_now, lowpri_q);
        svc_ch   = top_of(isr_q, lowpri_q);
        found    = (sel_ch >= 0);
        sel_idx  = found ? ID_W'(sel_ch) : '0;

        set_mask = '0;
        if (state_q == S_RESOLVE && found) begin
            set_mask[sel_idx] = 1'b1;
        end
        // A fresh edge in the acknowledge cycle re-arms the request.
        ack_clr = set_mask & ~trig_q;
        rise    = ir_i & ~ir_q;
        irr_d   = (trig_q & ir_i) | (~trig_q & ((irr_q & ~ack_clr) | rise));

        eoi_clr  = '0;
        lowpri_d = lowpri_q;
        lvl      = int'(wdata_i[4:0]);
        if (cs_i && wr_i && addr_i == 3'd4) begin
            if (wdata_i[8]) begin
                if (lvl < NUM_IRQ && isr_q[ID_W'(lvl)]) begin
                    eoi_clr[ID_W'(lvl)] = 1'b1;
                    if (ctrl_q[0]) lowpri_d = ID_W'(lvl);
                end
            end else if (svc_ch >= 0) begin
                eoi_clr[ID_W'(svc_ch)] = 1'b1;
                if (ctrl_q[0]) lowpri_d = ID_W'(svc_ch);
            end
        end
        if (state_q == S_VECTOR && ctrl_q[1] && !spurious_q) begin
            eoi_clr[sel_q] = 1'b1;
            if (ctrl_q[0]) lowpri_d = sel_q;
        end
        isr_d = (isr_q & ~eoi_clr) | set_mask;
        int_d = |eligible(irr_q & ~ack_clr, imr_q, isr_d, lowpri_d);

        case (addr_i)
            3'd0:    rd_mux = {30'd0, ctrl_q};
            3'd1:    rd_mux = 32'(imr_q);
            3'd2:    rd_mux = 32'(trig_q);
            3'd3:    rd_mux = {24'd0, vbase_q};
            3'd5:    rd_mux = 32'(irr_q);
            3'd6:    rd_mux = 32'(isr_q);
            3'd7:    rd_mux = 32'(lowpri_q);
            default: rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            ctrl_q      <= 2'd0;
            imr_q       <= '1;
            trig_q      <= '0;
            vbase_q     <= 8'd0;
            irr_q       <= '0;
            isr_q       <= '0;
            ir_q        <= '0;
            lowpri_q    <= ID_W'(NUM_IRQ - 1);
            sel_q       <= '0;
            rdata_q     <= 32'd0;
            int_q       <= 1'b0;
            vec_valid_q <= 1'b0;
            vector_q    <= 8'd0;
            spurious_q  <= 1'b0;
        end else begin
            ir_q        <= ir_i;
            irr_q       <= irr_d;
            isr_q       <= isr_d;
            lowpri_q    <= lowpri_d;
            int_q       <= int_d;
            vec_valid_q <= 1'b0;
            spurious_q  <= 1'b0;
            if (cs_i && wr_i) begin
                case (addr_i)
                    3'd0:    ctrl_q  <= wdata_i[1:0];
                    3'd1:    imr_q   <= wdata_i[NUM_IRQ-1:0];
                    3'd2:    trig_q  <= wdata_i[NUM_IRQ-1:0];
                    3'd3:    vbase_q <= wdata_i[7:0];
                    default: ;
                endcase
            end
            if (cs_i && rd_i) begin
                rdata_q <= rd_mux;
            end
            case (state_q)
                S_IDLE: begin
                    if (inta_i) state_q <= S_RESOLVE;
                end
                S_RESOLVE: begin
                    state_q     <= S_VECTOR;
                    sel_q       <= sel_idx;
                    vec_valid_q <= 1'b1;
                    spurious_q  <= !found;
                    vector_q    <= found ? vbase_q + 8'(sel_idx) : vbase_q + 8'(NUM_IRQ - 1);
                end
                S_VECTOR: state_q <= S_IDLE;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    assign rdata_o     = rdata_q;
    assign int_o       = int_q;
    assign vec_valid_o = vec_valid_q;
    assign vector_o    = vector_q;
    assign spurious_o  = spurious_q;
endmodule

// File: tb/tb_pic_sync_controller.sv
// tb/tb_pic_sync_controller.sv - scoreboard bench for pic_sync_controller
module tb_pic_sync_controller;
    localparam int N = 8;

    typedef struct {
        logic [7:0] vec;
        logic       sp;
        int         due;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst = 1'b1, cs = 1'b0, wr = 1'b0, rd = 1'b0, inta = 1'b0;
    logic [N-1:0] ir = '0;
    logic [2:0]   addr = '0;
    logic [31:0]  wdata = '0;
    logic [31:0]  rdata;
    logic         int_w, vec_valid, spurious;
    logic [7:0]   vector;

    logic         rst32 = 1'b1, cs32 = 1'b0, wr32 = 1'b0, rd32 = 1'b0, inta32 = 1'b0;
    logic [31:0]  ir32 = '0;
    logic [2:0]   addr32 = '0;
    logic [31:0]  wdata32 = '0;
    logic [31:0]  rdata32;
    logic         int32, vv32, sp32;
    logic [7:0]   vec32;

    pic_sync_controller #(.NUM_IRQ(N)) dut (
        .clk_i(clk), .rst_i(rst), .ir_i(ir), .cs_i(cs), .wr_i(wr), .rd_i(rd),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata), .inta_i(inta),
        .int_o(int_w), .vec_valid_o(vec_valid), .vector_o(vector), .spurious_o(spurious)
    );

    pic_sync_controller #(.NUM_IRQ(32)) dut32 (
        .clk_i(clk), .rst_i(rst32), .ir_i(ir32), .cs_i(cs32), .wr_i(wr32), .rd_i(rd32),
        .addr_i(addr32), .wdata_i(wdata32), .rdata_o(rdata32), .inta_i(inta32),
        .int_o(int32), .vec_valid_o(vv32), .vector_o(vec32), .spurious_o(sp32)
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    exp_t        vq[$];
    logic [31:0] rq[$];

    // Architectural model of the controller's registers.
    logic [N-1:0] m_irr, m_isr, m_imr, m_trig, m_ir;
    logic [1:0]   m_ctrl;
    logic [7:0]   m_vbase;
    int           m_lowpri;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        vectors++;
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s: actual %0h required %0h", name, act, req);
        end
    endtask

    function automatic int m_rank(input int c);
        return (c - m_lowpri - 1 + 2 * N) % N;
    endfunction

    function automatic int m_best(input logic [N-1:0] mask);
        for (int i = 0; i < N; i++) begin
            int c;
            c = (m_lowpri + 1 + i) % N;
            if (mask[c]) return c;
        end
        return -1;
    endfunction

    function automatic logic [N-1:0] m_elig();
        logic [N-1:0] e;
        int t;
        e = '0;
        t = m_best(m_isr);
        for (int c = 0; c < N; c++) begin
            if (m_irr[c] && !m_imr[c] && (t < 0 || m_rank(c) < m_rank(t))) e[c] = 1'b1;
        end
        return e;
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        case (a)
            3'd0:    return {30'd0, m_ctrl};
            3'd1:    return 32'(m_imr);
            3'd2:    return 32'(m_trig);
            3'd3:    return {24'd0, m_vbase};
            3'd5:    return 32'(m_irr);
            3'd6:    return 32'(m_isr);
            3'd7:    return 32'(m_lowpri);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_irr = '0; m_isr = '0; m_imr = '1; m_trig = '0; m_ir = '0;
        m_ctrl = 2'd0; m_vbase = 8'd0; m_lowpri = N - 1;
    endtask

    task automatic model_ir(input logic [N-1:0] nw);
        for (int c = 0; c < N; c++) begin
            if (m_trig[c]) m_irr[c] = nw[c];
            else if (nw[c] && !m_ir[c]) m_irr[c] = 1'b1;
        end
        m_ir = nw;
    endtask

    task automatic model_write(input logic [2:0] a, input logic [31:0] d);
        int j;
        int lvl;
        case (a)
            3'd0: m_ctrl = d[1:0];
            3'd1: m_imr = d[N-1:0];
            3'd2: begin
                m_trig = d[N-1:0];
                for (int c = 0; c < N; c++) if (m_trig[c]) m_irr[c] = m_ir[c];
            end
            3'd3: m_vbase = d[7:0];
            3'd4: begin
                j = -1;
                lvl = int'(d[4:0]);
                if (d[8]) begin
                    if (lvl < N) begin
                        if (m_isr[lvl]) j = lvl;
                    end
                end else begin
                    j = m_best(m_isr);
                end
                if (j >= 0) begin
                    m_isr[j] = 1'b0;
                    if (m_ctrl[0]) m_lowpri = j;
                end
            end
            default: ;
        endcase
    endtask

    task automatic model_ack(output exp_t e);
        int k;
        k = m_best(m_elig());
        e.due = 0;
        if (k >= 0) begin
            m_isr[k] = 1'b1;
            if (!m_trig[k]) m_irr[k] = 1'b0;
            e.vec = m_vbase + 8'(k);
            e.sp  = 1'b0;
            if (m_ctrl[1]) begin
                m_isr[k] = 1'b0;
                if (m_ctrl[0]) m_lowpri = k;
            end
        end else begin
            e.vec = m_vbase + 8'(N - 1);
            e.sp  = 1'b1;
        end
    endtask

    logic rd_seen = 1'b0;
    always @(negedge clk) begin
        exp_t        e;
        logic [31:0] r;
        if (rd_seen) begin
            if (rq.size() == 0) check("rdata_unexpected", 32'd1, 32'd0);
            else begin
                r = rq.pop_front();
                check("rdata", rdata, r);
            end
        end
        rd_seen = cs & rd & !rst;
        if (vec_valid === 1'b1) begin
            if (vq.size() == 0) check("vec_valid_unexpected", 32'd1, 32'd0);
            else begin
                e = vq.pop_front();
                check("vector", {24'd0, vector}, {24'd0, e.vec});
                check("spurious", {31'd0, spurious}, {31'd0, e.sp});
                check("vec_cycle", cycle, e.due);
            end
        end else if (vq.size() != 0 && cycle > vq[0].due) begin
            check("vec_valid_missing", 32'd0, 32'd1);
            void'(vq.pop_front());
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; ir = '0; inta = 1'b0; cs = 1'b0; wr = 1'b0; rd = 1'b0;
        tick(2);
        rst = 1'b0;
        model_reset();
        tick(1);
    endtask

    task automatic set_ir(input logic [N-1:0] nw);
        ir = nw;
        model_ir(nw);
        tick(3);
        check("int_after_ir", {31'd0, int_w}, {31'd0, |m_elig()});
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        cs = 1'b1; wr = 1'b1; addr = a; wdata = d;
        tick(1);
        cs = 1'b0; wr = 1'b0;
        model_write(a, d);
        tick(3);
        check("int_after_write", {31'd0, int_w}, {31'd0, |m_elig()});
    endtask

    task automatic reg_read(input logic [2:0] a, input int want);
        rq.push_back(want >= 0 ? 32'(want) : m_read(a));
        cs = 1'b1; rd = 1'b1; addr = a;
        tick(1);
        cs = 1'b0; rd = 1'b0;
        tick(2);
    endtask

    task automatic push_ack(input int want_vec, input int want_sp);
        exp_t e;
        model_ack(e);
        e.due = cycle + 2;
        if (want_vec >= 0) begin
            e.vec = 8'(want_vec);
            e.sp  = want_sp[0];
        end
        vq.push_back(e);
    endtask

    task automatic inta_op(input int new_ir, input int want_vec, input int want_sp);
        if (new_ir >= 0) begin
            ir = N'(new_ir);
            model_ir(N'(new_ir));
        end
        push_ack(want_vec, want_sp);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        tick(4);
        check("int_after_ack", {31'd0, int_w}, {31'd0, |m_elig()});
    endtask

    task automatic w32(input logic [2:0] a, input logic [31:0] d);
        cs32 = 1'b1; wr32 = 1'b1; addr32 = a; wdata32 = d;
        tick(1);
        cs32 = 1'b0; wr32 = 1'b0;
        tick(1);
    endtask

    task automatic r32(input logic [2:0] a, input logic [31:0] req, input string name);
        cs32 = 1'b1; rd32 = 1'b1; addr32 = a;
        tick(1);
        cs32 = 1'b0; rd32 = 1'b0;
        check(name, rdata32, req);
    endtask

    initial begin
        model_reset();
        tick(3);
        rst = 1'b0;
        rst32 = 1'b0;
        tick(1);
        check("reset_int", {31'd0, int_w}, 32'd0);
        check("reset_vec_valid", {31'd0, vec_valid}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        reg_read(3'd1, 'hFF);
        set_ir(8'h08);
        check("masked_int", {31'd0, int_w}, 32'd0);
        set_ir(8'h00);

        // Basic edge request, INT latency and acknowledge
        do_reset();
        reg_write(3'd1, 32'h0);
        reg_write(3'd3, 32'h40);
        ir = 8'h08;
        model_ir(8'h08);
        tick(1);
        check("int_edge_n1", {31'd0, int_w}, 32'd0);
        tick(1);
        check("int_edge_n2", {31'd0, int_w}, 32'd1);
        set_ir(8'h00);
        push_ack('h43, 0);
        inta = 1'b1;
        tick(1);
        inta = 1'b0;
        tick(1);
        check("int_drop_n2", {31'd0, int_w}, 32'd0);
        tick(3);
        reg_read(3'd6, 'h08);
        reg_read(3'd5, 'h00);
        reg_write(3'd4, 32'h000);
        reg_read(3'd6, 'h00);

        // Nesting
        set_ir(8'h20); set_ir(8'h00);
        inta_op(-1, 'h45, 0);
        reg_read(3'd6, 'h20);
        set_ir(8'h40);
        check("nest_lower_int", {31'd0, int_w}, 32'd0);
        set_ir(8'h00);
        set_ir(8'h04);
        check("nest_higher_int", {31'd0, int_w}, 32'd1);
        set_ir(8'h00);
        inta_op(-1, 'h42, 0);
        reg_read(3'd6, 'h24);
        reg_write(3'd4, 32'h000);
        reg_read(3'd6, 'h20);
        reg_write(3'd4, 32'h000);
        check("nest_pending_int", {31'd0, int_w}, 32'd1);
        inta_op(-1, 'h46, 0);
        reg_write(3'd4, 32'h109);
        reg_read(3'd6, 'h40);
        reg_write(3'd4, 32'h106);
        reg_read(3'd6, 'h00);

        // Rotation with automatic EOI
        reg_write(3'd0, 32'h3);
        set_ir(8'h03); set_ir(8'h00);
        inta_op(-1, 'h40, 0);
        reg_read(3'd7, 0);
        reg_read(3'd6, 0);
        inta_op(-1, 'h41, 0);
        reg_read(3'd7, 1);
        reg_read(3'd6, 0);
        reg_write(3'd0, 32'h0);

        // Level request withdrawn before resolve
        reg_write(3'd2, 32'h10);
        set_ir(8'h10);
        check("level_int", {31'd0, int_w}, 32'd1);
        inta_op(0, 'h47, 1);
        reg_read(3'd6, 0);
        reg_write(3'd2, 32'h0);

        // Randomised traffic against the model
        for (int t = 0; t < 400; t++) begin
            int op;
            op = $urandom_range(0, 11);
            case (op)
                0, 1, 2: set_ir(N'($urandom & $urandom));
                3:       reg_write(3'd1, $urandom & $urandom & $urandom);
                4:       reg_write(3'd2, $urandom & $urandom);
                5:       reg_write(3'd0, $urandom);
                6:       reg_write(3'd4, ($urandom_range(0, 1) << 8) | $urandom_range(0, 31));
                7:       reg_write(3'($urandom_range(3, 7)) == 3'd4 ? 3'd3 : 3'($urandom_range(5, 7)), $urandom);
                8, 9:    inta_op(-1, -1, 0);
                default: reg_read(3'($urandom_range(0, 7)), -1);
            endcase
        end

        // 32-channel instance: vector wrap and reset mid-handshake
        rst32 = 1'b1;
        tick(2);
        rst32 = 1'b0;
        tick(1);
        r32(3'd1, 32'hFFFF_FFFF, "imr32_reset");
        w32(3'd1, 32'h0);
        w32(3'd3, 32'hF0);
        ir32 = 32'h0010_0000;
        tick(1);
        ir32 = '0;
        tick(3);
        check("int32", {31'd0, int32}, 32'd1);
        inta32 = 1'b1;
        tick(1);
        inta32 = 1'b0;
        check("vv32_resolve", {31'd0, vv32}, 32'd0);
        tick(1);
        check("vv32", {31'd0, vv32}, 32'd1);
        check("vec32_wrap", {24'd0, vec32}, 32'h04);
        check("sp32", {31'd0, sp32}, 32'd0);
        tick(2);
        r32(3'd6, 32'h0010_0000, "isr32");
        w32(3'd4, 32'h114);
        r32(3'd6, 32'h0, "isr32_eoi");
        ir32 = 32'h0000_0080;
        tick(1);
        ir32 = '0;
        tick(3);
        inta32 = 1'b1;
        tick(1);
        inta32 = 1'b0;
        rst32 = 1'b1;
        tick(1);
        check("vv32_rst_a", {31'd0, vv32}, 32'd0);
        tick(1);
        check("vv32_rst_b", {31'd0, vv32}, 32'd0);
        rst32 = 1'b0;
        tick(2);
        check("vv32_rst_c", {31'd0, vv32}, 32'd0);
        r32(3'd6, 32'h0, "isr32_after_rst");
        check("int32_after_rst", {31'd0, int32}, 32'd0);

        tick(5);
        check("sb_vec_drain", vq.size(), 32'd0);
        check("sb_rd_drain", rq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
